// File: rtl/led_seq_pkg.sv
// Shared mode encoding and mode-advance helper for the LED sequencer.
// Latency: none (types and a pure function only).
// Backpressure: none.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    // Fixed button-press cycle: STATIC -> CHASE -> BOUNCE -> COUNT -> STATIC.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_STATIC: return MODE_CHASE;
            MODE_CHASE:  return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_COUNT;
            default:     return MODE_STATIC;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises, debounces and edge-detects a raw asynchronous push button.
// Latency: 2 sync + DEBOUNCE_CYCLES stable clocks until level/press update.
// Backpressure: none; press is a single-cycle pulse that is never held.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES clocks in a row;
    // any clock where it matches again restarts the run from zero.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchroniser plus debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Button-selected LED pattern generator: static, chase, bounce and binary count.
// Latency: mode changes one clock after the debounced press; led is registered.
// Backpressure: none; steps are paced by the prescaler and switch divisor.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRESCALE        = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LED_W-1:0] switch,
    input  logic             joy_select,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode
);

    localparam int PW = $clog2(PRESCALE);

    logic             btn_level, press, adv;
    logic             tick, step;
    mode_e            mode_q, mode_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             dir_q, dir_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [LED_W-1:0] step_q, step_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (joy_select),
        .level (btn_level),
        .press (press)
    );

    // A press pulse only ever accompanies a high accepted level.
    assign adv  = press & btn_level;
    assign tick = (pre_q == PW'(PRESCALE - 1));
    // >= rather than == so lowering switch below the count steps on the next tick.
    assign step = tick && (step_q >= switch);

    // Next mode / pattern; a mode change wins over a coincident step.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        pre_d  = tick ? '0 : pre_q + 1'b1;
        step_d = step_q;
        if (tick) begin
            step_d = step ? '0 : step_q + 1'b1;
        end
        if (adv) begin
            mode_d = next_mode(mode_q);
            pre_d  = '0;
            step_d = '0;
            dir_d  = 1'b1;
            case (mode_d)
                MODE_STATIC: led_d = switch;
                MODE_COUNT:  led_d = '0;
                default:     led_d = LED_W'(1);
            endcase
        end else begin
            case (mode_q)
                MODE_STATIC: led_d = switch;
                MODE_CHASE: begin
                    if (step) led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                end
                MODE_BOUNCE: begin
                    if (step) begin
                        if (dir_q) begin
                            if (led_q[LED_W-1]) begin
                                led_d = led_q >> 1;
                                dir_d = 1'b0;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d = led_q << 1;
                                dir_d = 1'b1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                end
                default: begin
                    if (step) led_d = led_q + 1'b1;
                end
            endcase
        end
    end

    // State registers: mode, pattern, bounce direction (1 = left), prescaler, step count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_STATIC;
            led_q  <= '0;
            dir_q  <= 1'b1;
            pre_q  <= '0;
            step_q <= '0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            pre_q  <= pre_d;
            step_q <= step_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer with LED_W=8, DEBOUNCE_CYCLES=4, PRESCALE=2.
// A step-count based model is compared against led/mode every cycle,
// and directed scenarios pin hand-computed values.
module tb_led_sequencer;

    localparam int W = 8;
    localparam int D = 4;
    localparam int P = 2;
    localparam logic [7:0] BEXP [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         joy;
    logic [W-1:0] led;
    logic [1:0]   mode;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    led_sequencer #(.LED_W(W), .DEBOUNCE_CYCLES(D), .PRESCALE(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .switch     (sw),
        .joy_select (joy),
        .led        (led),
        .mode       (mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_mode, m_cyc, m_tsince, m_k;
    logic [W-1:0] m_led;
    bit           m_level, m_pend;
    bit           rawh[$];

    // Pattern after k steps since entering a mode.
    function automatic logic [W-1:0] pattern(input int md, input int k);
        int p;
        case (md)
            1: return W'(1) << (k % W);
            2: begin
                p = k % (2*W - 2);
                return W'(1) << ((p < W) ? p : (2*W - 2 - p));
            end
            3: return W'(k % (1 << W));
            default: return '0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_led = '0; m_cyc = 0; m_tsince = 0; m_k = 0;
            m_level = 1'b0; m_pend = 1'b0;
            rawh = {};
            for (int i = 0; i < D + 2; i++) rawh.push_back(1'b0);
        end else begin
            bit flip;
            // synchronised value seen before edge n is the raw sample of edge n-2
            flip = 1'b1;
            for (int i = 0; i < D; i++)
                if (rawh[rawh.size() - 2 - i] == m_level) flip = 1'b0;
            if (m_pend) begin
                m_mode = (m_mode + 1) % 4;
                m_cyc = 0; m_tsince = 0; m_k = 0;
                m_led = (m_mode == 0) ? sw : (m_mode == 3) ? W'(0) : W'(1);
            end else begin
                m_cyc++;
                if (m_mode == 0) m_led = sw;
                if (m_cyc % P == 0) begin
                    if (m_tsince >= int'(sw)) begin
                        m_tsince = 0;
                        m_k++;
                        if (m_mode != 0) m_led = pattern(m_mode, m_k);
                    end else begin
                        m_tsince++;
                    end
                end
            end
            m_pend = 1'b0;
            if (flip) begin
                m_level = ~m_level;
                m_pend  = m_level;
            end
            rawh.push_back(joy);
            void'(rawh.pop_front());
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_led", 32'(led), 32'(m_led));
            check("model_mode", 32'(mode), 32'(m_mode[1:0]));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int lat, t;
        rst_n = 1'b0;
        sw    = 8'h80;
        joy   = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_led", 32'(led), 32'h0);
        check("reset_mode", 32'(mode), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_led", 32'(led), 32'h80);
        check("first_mode", 32'(mode), 32'h0);

        // glitch of 3 clocks must not advance the mode
        sw = 8'h01;
        @(negedge clk); joy = 1'b1;
        repeat (3) @(negedge clk);
        joy = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_mode", 32'(mode), 32'h0);

        // clean press: mode changes on the 7th edge after the raise
        joy = 1'b1;
        lat = 0; t = 0;
        while (lat == 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
            if (mode != 2'd0) lat = t;
        end
        check("press_latency", 32'(lat), 32'd7);
        check("chase_mode", 32'(mode), 32'h1);
        check("chase_load", 32'(led), 32'h01);

        // CHASE every 4 clocks, press landing on a step, then BOUNCE, then COUNT
        for (int t2 = 1; t2 <= 80; t2++) begin
            @(posedge clk); #1;
            if (t2 == 3)  joy = 1'b0;
            if (t2 % 4 == 0 && t2 <= 36) check("chase_step", 32'(led), 32'(W'(1) << ((t2 / 4) % 8)));
            if (t2 == 33) joy = 1'b1;
            if (t2 == 40) begin
                check("coincide_mode", 32'(mode), 32'h2);
                check("coincide_led", 32'(led), 32'h01);
                sw = 8'h00;
            end
            if (t2 == 43) joy = 1'b0;
            if (t2 > 40 && t2 <= 70 && (t2 - 40) % 2 == 0)
                check("bounce_step", 32'(led), 32'(BEXP[(t2 - 40) / 2 - 1]));
            if (t2 == 70) joy = 1'b1;
            if (t2 == 77) begin
                check("count_mode", 32'(mode), 32'h3);
                check("count_load", 32'(led), 32'h00);
            end
        end
        joy = 1'b0;

        // COUNT with switch=0: one step per 2 clocks, wraps 0xFF -> 0x00
        for (int c = 4; c <= 520; c++) begin
            @(posedge clk); #1;
            if (c == 510) check("count_ff", 32'(led), 32'hFF);
            if (c == 512) check("count_wrap", 32'(led), 32'h00);
        end
        check("count_pre_drop", 32'(led), 32'h04);
        sw = 8'h20;
        for (int c = 521; c <= 542; c++) begin
            @(posedge clk); #1;
            if (c == 540) begin
                check("count_hold", 32'(led), 32'h04);
                sw = 8'h01;
            end
            if (c == 541) check("drop_wait", 32'(led), 32'h04);
            if (c == 542) check("drop_step", 32'(led), 32'h05);
        end

        // reset in the middle of a debounce: abort, no press on release
        @(negedge clk); joy = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_led", 32'(led), 32'h0);
        check("midreset_mode", 32'(mode), 32'h0);
        joy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("postreset_mode", 32'(mode), 32'h0);
        check("postreset_led", 32'(led), 32'h01);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter LED_W, default 8: number of switches and LEDs (4..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clocks required to accept a button level.
REQ-003 Parameter PRESCALE, default 100000: clocks per base tick (2 or more).
REQ-004 Port clk  input  1: system clock; all logic is on the rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port switch  input  LED_W: static pattern in STATIC mode, and the step-period divisor in all other modes.
REQ-007 Port joy_select  input  1: raw, asynchronous, bouncy, active-high mode-advance button.
REQ-008 Port led  output  LED_W: registered LED pattern.
REQ-009 Port mode  output  2: registered current mode (0 STATIC, 1 CHASE, 2 BOUNCE, 3 COUNT).

Function
REQ-010 joy_select SHALL pass through a 2-FF synchroniser before any other use.
REQ-011 Debouncer: the accepted level SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive clocks; any interruption SHALL restart the count from 0.
REQ-012 A 0->1 transition of the accepted level SHALL produce a one-cycle press pulse; 1->0 SHALL produce nothing.
REQ-013 On a press pulse, mode SHALL advance on the next edge: STATIC->CHASE->BOUNCE->COUNT->STATIC.
REQ-014 Press-to-mode latency SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 clocks from the first synchronised-high sample.
REQ-015 Prescaler SHALL count 0..PRESCALE-1 and wrap; the wrap cycle SHALL produce a one-cycle base tick.
REQ-016 Step counter SHALL increment on each base tick and SHALL issue a step when the count is >= switch before incrementing, then clear. Step period = (switch+1) base ticks.
REQ-017 The >= comparison SHALL ensure that reducing switch below the current count yields a step on the next base tick, with no 2^LED_W wrap lockout.
REQ-018 STATIC mode: led SHALL equal switch registered one cycle later, independent of steps.
REQ-019 CHASE mode: led SHALL hold a single set bit and rotate left one position per step; MSB SHALL wrap to LSB.
REQ-020 BOUNCE mode: led SHALL hold a single set bit moving one position per step. The direction SHALL reverse on reaching the MSB (next step gives MSB-1) or the LSB (next step gives bit 1). There SHALL be no dwell at either end.
REQ-021 COUNT mode: led SHALL increment by 1 per step, modulo 2^LED_W; all-ones SHALL wrap to 0.
REQ-022 On a mode change, the step counter and prescaler SHALL clear, and the pattern SHALL load as follows: CHASE and BOUNCE load 1 with direction left; COUNT loads 0; STATIC loads switch.
REQ-023 If a step and a press pulse fall in the same cycle, the mode change SHALL win and the step SHALL be discarded.

Reset
REQ-024 While rst_n=0, the outputs SHALL be led=0 and mode=STATIC.
REQ-025 While rst_n=0, the internals SHALL be: synchroniser=0, accepted level=0, debounce count=0, prescaler=0, step counter=0, direction=left.
REQ-026 Reset asserted mid-pattern or mid-debounce SHALL abort immediately, and the block SHALL NOT generate a press on release.
REQ-027 The first edge after deassertion SHALL load led=switch (STATIC mode).

Structure
REQ-028 Package led_seq_pkg SHALL hold the 2-bit mode enum (MODE_STATIC, MODE_CHASE, MODE_BOUNCE, MODE_COUNT) and a next-mode function.
REQ-029 Synchroniser, debouncer and edge detect SHALL form one sub-module, button_debounce, parameterised by DEBOUNCE_CYCLES, with outputs level and press.
REQ-030 Prescaler, step counter and pattern FSM SHALL reside in led_sequencer.

Verification (LED_W=8, DEBOUNCE_CYCLES=4, PRESCALE=2)
REQ-031 Reset with switch=0x80, then release -> one clock later led=0x80 and mode=0.
REQ-032 Glitch joy_select high for 3 clocks, then clean high for 10 clocks -> the glitch produces no mode change; exactly one advance to mode=1, 7 clocks after the clean rise is first synchronised.
REQ-033 CHASE with switch=1 -> led steps 0x01,0x02,...,0x80,0x01 every 4 clocks.
REQ-034 BOUNCE with switch=0 -> led sequence 0x01,0x02,...,0x80,0x40,...,0x01,0x02, one step per 2 clocks.
REQ-035 COUNT with switch=0, run 512 clocks -> led wraps 0xFF->0x00. Drop switch 0x20->0x01 while the step count is 10 -> a step occurs on the next base tick.
REQ-036 Press coincident with a CHASE step -> mode=2, led=0x01, and the step is not applied.
